// File: rtl/fma_round_pkg.sv
// Shared types and helpers for the fma rounding pipeline.
// Flags are packed as {of, uf, nx}, matching the out_flags port layout.
package fma_round_pkg;

   typedef enum logic [1:0] {
      RZ  = 2'b00,
      RNE = 2'b01,
      RN  = 2'b10,
      RP  = 2'b11
   } rm_t;

   typedef struct packed {
      logic of;
      logic uf;
      logic nx;
   } round_flags_t;

   // Largest finite magnitude {exp, frac}, without the sign bit
   function automatic logic [63:0] max_finite(int unsigned ne, int unsigned nf);
      logic [63:0] e;
      e = (64'd1 << ne) - 64'd2;
      return (e << nf) | ((64'd1 << nf) - 64'd1);
   endfunction

endpackage

// File: rtl/fma_round_decide.sv
// Round-up / inexact decision for one rounding mode.
// Inputs are the kept LSB, the guard bit and the OR of all lower bits.
module fma_round_decide
   import fma_round_pkg::*;
(
   input  rm_t  rm,
   input  logic sign,
   input  logic lsb,
   input  logic guard,
   input  logic trail,
   output logic inc,
   output logic inexact
);

   always_comb begin
      inexact = guard | trail;
      inc     = 1'b0;
      unique case (rm)
         RZ:      inc = 1'b0;
         RNE:     inc = guard & (lsb | trail);
         RN:      inc = sign & (guard | trail);
         RP:      inc = ~sign & (guard | trail);
         default: inc = 1'b0;
      endcase
   end

endmodule

// File: rtl/fma_round_pipe.sv
// Two-stage IEEE-754 rounder: stage 1 denormalises and decides the increment,
// stage 2 adds, handles carry/overflow and packs the result with flags.
module fma_round_pipe
   import fma_round_pkg::*;
#(
   parameter int unsigned NE = 5,
   parameter int unsigned NF = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [NE+1:0]    in_exp,
   input  logic [NF+2:0]    in_sig,
   input  logic             in_sticky,
   input  logic [1:0]       in_rm,
   input  logic             in_special,
   input  logic [NE+NF:0]   in_special_val,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NE+NF:0]   out_result,
   output logic [2:0]       out_flags
);

   localparam int unsigned SW  = NF + 3;
   localparam int unsigned SHW = $clog2(NF + 4);
   localparam logic [63:0] MAX_FIN = max_finite(NE, NF);

   // ---------------- stage 1: denormalise + decide ----------------
   logic signed [NE+1:0] expS;
   logic                 tinyD;
   int                   shInt;
   logic [SHW-1:0]       shamt;
   logic [2*SW-1:0]      shifted;
   logic [SW-1:0]        sigD;
   logic                 stickyD;
   logic [NE+1:0]        expD;
   logic                 incD;
   logic                 inexactD;

   assign expS = $signed(in_exp);

   always_comb begin
      tinyD = expS[NE+1] | (expS == '0);
      shInt = 1 - int'(expS);
      if (shInt > int'(SW)) shInt = int'(SW);
      shamt = tinyD ? shInt[SHW-1:0] : '0;
      // Low half collects everything shifted past R so it can fold into sticky
      shifted = {in_sig, {SW{1'b0}}} >> shamt;
      sigD    = shifted[2*SW-1:SW];
      stickyD = in_sticky | (|shifted[SW-1:0]);
      expD    = tinyD ? '0 : in_exp;
   end

   fma_round_decide uDecide (
      .rm      (rm_t'(in_rm)),
      .sign    (in_sign),
      .lsb     (sigD[2]),
      .guard   (sigD[1]),
      .trail   (sigD[0] | stickyD),
      .inc     (incD),
      .inexact (inexactD)
   );

   logic          s1Valid;
   logic          s1Sign;
   logic [NE+1:0] s1Exp;
   logic [NF:0]   s1Sig;
   logic          s1Inc;
   logic          s1Inexact;
   logic          s1Tiny;
   rm_t           s1Rm;
   logic          s1Special;
   logic [NE+NF:0] s1SpecialVal;

   logic s2Valid;
   logic s1Adv;

   assign s1Adv    = ~s2Valid | out_ready;
   assign in_ready = ~s1Valid | s1Adv;

   always_ff @(posedge clk) begin
      if (in_valid & in_ready) begin
         s1Sign       <= in_sign;
         s1Exp        <= expD;
         s1Sig        <= sigD[NF+2:2];
         s1Inc        <= incD;
         s1Inexact    <= inexactD;
         s1Tiny       <= tinyD;
         s1Rm         <= rm_t'(in_rm);
         s1Special    <= in_special;
         s1SpecialVal <= in_special_val;
      end
   end

   // ---------------- stage 2: increment + pack ----------------
   logic [NF+1:0]        sum;
   logic signed [NE+1:0] expF;
   logic [NF-1:0]        frac;
   logic                 ovf;
   logic                 toInf;
   logic [NE+NF:0]       resD;
   round_flags_t         flagsD;

   always_comb begin
      sum = {1'b0, s1Sig} + (NF+2)'(s1Inc);
      // A subnormal that rounds into the hidden bit becomes the minimum normal
      if (s1Tiny) expF = (NE+2)'(sum[NF]);
      else        expF = s1Exp + (NE+2)'(sum[NF+1]);
      frac  = sum[NF+1] ? '0 : sum[NF-1:0];
      ovf   = ~expF[NE+1] & (expF[NE:0] >= (NE+1)'((1 << NE) - 1));
      toInf = (s1Rm == RNE) | ((s1Rm == RP) & ~s1Sign) | ((s1Rm == RN) & s1Sign);

      if (s1Special)  resD = s1SpecialVal;
      else if (ovf)   resD = toInf ? {s1Sign, {NE{1'b1}}, {NF{1'b0}}}
                                   : {s1Sign, MAX_FIN[NE+NF-1:0]};
      else            resD = {s1Sign, expF[NE-1:0], frac};

      flagsD = '0;
      if (!s1Special) begin
         flagsD.of = ovf;
         flagsD.uf = s1Tiny & s1Inexact;
         flagsD.nx = s1Inexact | ovf;
      end
   end

   logic [NE+NF:0] resQ;
   round_flags_t   flagsQ;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1Valid <= 1'b0;
         s2Valid <= 1'b0;
         resQ    <= '0;
         flagsQ  <= '0;
      end else begin
         if (in_ready) s1Valid <= in_valid;
         if (s1Adv) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
               resQ   <= resD;
               flagsQ <= flagsD;
            end
         end
      end
   end

   assign out_valid  = s2Valid;
   assign out_result = resQ;
   assign out_flags  = flagsQ;

endmodule
